// File: rtl/tlight_pkg.sv
// Shared types and helpers for the four-way intersection light controller.
// State codes double as the debug phase output.
package tlight_pkg;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_PFLASH = 3'd2,
        ST_YELLOW = 3'd3,
        ST_LEFT   = 3'd4,
        ST_NIGHT  = 3'd5
    } tl_state_e;

    localparam int unsigned APP_W = 0;
    localparam int unsigned APP_E = 1;
    localparam int unsigned APP_S = 2;
    localparam int unsigned APP_N = 3;

    // Approach bits belonging to an axis: 0 -> {W,E}, 1 -> {S,N}.
    function automatic logic [3:0] axis_mask(input logic ax);
        logic [3:0] m;
        m = 4'b0000;
        if (ax) begin
            m[APP_S] = 1'b1;
            m[APP_N] = 1'b1;
        end else begin
            m[APP_W] = 1'b1;
            m[APP_E] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tlight_timer.sv
// Phase tick counter: counts ticks up to limit-1, then wraps to 0 and flags terminal.
// The limit is re-selected by the controller for every state.
module tlight_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             term
);

    logic [CNT_W-1:0] cnt_r;

    assign term = tick && (cnt_r == (limit - CNT_W'(1)));

    // Phase counter: clears on terminal so the next phase starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (term) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/tlight_ctrl.sv
// Two-axis intersection controller: phase FSM, pedestrian request latching and
// a registered lamp bus decoded from the next state so lamps change cleanly.
module tlight_ctrl
    import tlight_pkg::*;
#(
    parameter int GREEN_T  = 22,
    parameter int FLASH_T  = 7,
    parameter int YELLOW_T = 3,
    parameter int LEFT_T   = 8,
    parameter int ALLRED_T = 1,
    parameter int CNT_W    = 8
) (
    input  logic       Cp,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] ped_req,
    input  logic       night,
    output logic [3:0] veh_r,
    output logic [3:0] veh_y,
    output logic [3:0] veh_l,
    output logic [3:0] veh_g,
    output logic [3:0] ped_r,
    output logic [3:0] ped_g,
    output logic [1:0] ped_ack,
    output logic [2:0] phase,
    output logic       axis
);

    tl_state_e        state_r, state_s;
    logic             axis_r, axis_s;
    logic [1:0]       pend_r, pend_s;
    logic             walk_r, walk_s;
    logic             flash_r, flash_s;
    logic [1:0]       ack_s;
    logic [CNT_W-1:0] limit_s;
    logic             term_s;
    logic [3:0]       mask_s;
    logic [3:0]       veh_r_s, veh_y_s, veh_l_s, veh_g_s, ped_r_s, ped_g_s;

    tlight_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (Cp),
        .rst_n (reset),
        .tick  (tick),
        .limit (limit_s),
        .term  (term_s)
    );

    // Duration of the current phase; night advances on every tick.
    always_comb begin
        limit_s = CNT_W'(1);
        case (state_r)
            ST_ALLRED: limit_s = CNT_W'(ALLRED_T);
            ST_GREEN:  limit_s = CNT_W'(GREEN_T);
            ST_PFLASH: limit_s = CNT_W'(FLASH_T);
            ST_YELLOW: limit_s = CNT_W'(YELLOW_T);
            ST_LEFT:   limit_s = CNT_W'(LEFT_T);
            ST_NIGHT:  limit_s = CNT_W'(1);
            default:   limit_s = CNT_W'(1);
        endcase
    end

    // Next-state logic; requests latch every cycle, the served axis clears on green entry.
    always_comb begin
        state_s = state_r;
        axis_s  = axis_r;
        pend_s  = pend_r | ped_req;
        walk_s  = walk_r;
        flash_s = flash_r;
        ack_s   = 2'b00;
        case (state_r)
            ST_ALLRED: begin
                if (term_s && night) begin
                    state_s = ST_NIGHT;
                    flash_s = 1'b1;
                end else if (term_s) begin
                    state_s = ST_GREEN;
                    axis_s  = ~axis_r;
                    walk_s  = pend_s[axis_s];
                    if (walk_s) begin
                        pend_s[axis_s] = 1'b0;
                        ack_s[axis_s]  = 1'b1;
                    end else begin
                        ack_s = 2'b00;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_GREEN: begin
                if (term_s) begin
                    state_s = ST_PFLASH;
                    flash_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PFLASH: begin
                if (term_s) begin
                    state_s = ST_YELLOW;
                    walk_s  = 1'b0;
                end else if (tick) begin
                    flash_s = ~flash_r;
                end else begin
                    flash_s = flash_r;
                end
            end
            ST_YELLOW: begin
                if (term_s) begin
                    state_s = ST_LEFT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEFT: begin
                if (term_s) begin
                    state_s = ST_ALLRED;
                end else begin
                    state_s = state_r;
                end
            end
            ST_NIGHT: begin
                // Leaving night points axis at 1 so the first green goes to axis 0.
                if (tick && !night) begin
                    state_s = ST_ALLRED;
                    axis_s  = 1'b1;
                    flash_s = 1'b0;
                end else if (tick) begin
                    flash_s = ~flash_r;
                end else begin
                    flash_s = flash_r;
                end
            end
            default: begin
                state_s = ST_ALLRED;
                axis_s  = 1'b1;
                walk_s  = 1'b0;
                flash_s = 1'b0;
            end
        endcase
    end

    assign mask_s = axis_mask(axis_s);

    // Lamp decode from the next state so the lamp registers update with the state.
    always_comb begin
        veh_r_s = 4'hF;
        veh_y_s = 4'h0;
        veh_l_s = 4'h0;
        veh_g_s = 4'h0;
        ped_r_s = 4'hF;
        ped_g_s = 4'h0;
        case (state_s)
            ST_GREEN: begin
                veh_g_s = mask_s;
                veh_r_s = ~mask_s;
                if (walk_s) begin
                    ped_g_s = mask_s;
                    ped_r_s = ~mask_s;
                end else begin
                    ped_r_s = 4'hF;
                end
            end
            ST_PFLASH: begin
                veh_g_s = mask_s;
                veh_r_s = ~mask_s;
                if (walk_s) begin
                    ped_r_s = ~mask_s;
                    ped_g_s = flash_s ? mask_s : 4'h0;
                end else begin
                    ped_r_s = 4'hF;
                end
            end
            ST_YELLOW: begin
                veh_y_s = mask_s;
                veh_r_s = ~mask_s;
            end
            ST_LEFT: begin
                veh_l_s = mask_s;
                veh_r_s = 4'hF;
            end
            ST_NIGHT: begin
                veh_r_s = 4'h0;
                ped_r_s = 4'h0;
                veh_y_s = flash_s ? 4'hF : 4'h0;
            end
            default: begin
                veh_r_s = 4'hF;
                ped_r_s = 4'hF;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge Cp or negedge reset) begin
        if (!reset) begin
            state_r <= ST_ALLRED;
            axis_r  <= 1'b1;
            pend_r  <= 2'b00;
            walk_r  <= 1'b0;
            flash_r <= 1'b0;
        end else begin
            state_r <= state_s;
            axis_r  <= axis_s;
            pend_r  <= pend_s;
            walk_r  <= walk_s;
            flash_r <= flash_s;
        end
    end

    // Registered lamp bus and acknowledge pulses.
    always_ff @(posedge Cp or negedge reset) begin
        if (!reset) begin
            veh_r   <= 4'hF;
            veh_y   <= 4'h0;
            veh_l   <= 4'h0;
            veh_g   <= 4'h0;
            ped_r   <= 4'hF;
            ped_g   <= 4'h0;
            ped_ack <= 2'b00;
        end else begin
            veh_r   <= veh_r_s;
            veh_y   <= veh_y_s;
            veh_l   <= veh_l_s;
            veh_g   <= veh_g_s;
            ped_r   <= ped_r_s;
            ped_g   <= ped_g_s;
            ped_ack <= ack_s;
        end
    end

    assign phase = state_r;
    assign axis  = axis_r;

endmodule

// File: tb/tb_tlight_ctrl.sv
// Scoreboard bench for tlight_ctrl: a behavioural model predicts the full
// output bus per cycle; directed checks cover the documented sequences.
module tb_tlight_ctrl;

    localparam int GREEN_T  = 22;
    localparam int FLASH_T  = 7;
    localparam int YELLOW_T = 3;
    localparam int LEFT_T   = 8;
    localparam int ALLRED_T = 1;

    logic       Cp = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] ped_req;
    logic       night;
    logic [3:0] veh_r, veh_y, veh_l, veh_g, ped_r, ped_g;
    logic [1:0] ped_ack;
    logic [2:0] phase;
    logic       axis;

    int total = 0;
    int bad   = 0;

    logic [29:0] sb_q[$];
    logic [29:0] dut_vec;
    localparam logic [29:0] RST_VEC = {4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 2'b00, 3'd0, 1'b1};

    int         m_state;
    int         m_cnt;
    logic       m_axis, m_walk, m_flash;
    logic [1:0] m_pend, m_ack;

    tlight_ctrl #(
        .GREEN_T(GREEN_T), .FLASH_T(FLASH_T), .YELLOW_T(YELLOW_T),
        .LEFT_T(LEFT_T), .ALLRED_T(ALLRED_T), .CNT_W(8)
    ) dut (
        .Cp(Cp), .reset(reset), .tick(tick), .ped_req(ped_req), .night(night),
        .veh_r(veh_r), .veh_y(veh_y), .veh_l(veh_l), .veh_g(veh_g),
        .ped_r(ped_r), .ped_g(ped_g), .ped_ack(ped_ack), .phase(phase), .axis(axis)
    );

    always #5 Cp = ~Cp;

    assign dut_vec = {veh_r, veh_y, veh_l, veh_g, ped_r, ped_g, ped_ack, phase, axis};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] amask(input logic a);
        return a ? 4'b1100 : 4'b0011;
    endfunction

    task automatic m_reset();
        m_state = 0; m_cnt = 0; m_axis = 1'b1; m_walk = 1'b0;
        m_flash = 1'b0; m_pend = 2'b00; m_ack = 2'b00;
    endtask

    task automatic m_step(input logic t, input logic [1:0] pr, input logic n);
        m_ack  = 2'b00;
        m_pend = m_pend | pr;
        if (t) begin
            case (m_state)
                0: if (m_cnt == ALLRED_T - 1) begin
                       m_cnt = 0;
                       if (n) begin
                           m_state = 5; m_flash = 1'b1;
                       end else begin
                           m_state = 1; m_axis = ~m_axis; m_walk = m_pend[m_axis];
                           if (m_walk) begin
                               m_pend[m_axis] = 1'b0; m_ack[m_axis] = 1'b1;
                           end
                       end
                   end else m_cnt++;
                1: if (m_cnt == GREEN_T - 1) begin m_cnt = 0; m_state = 2; m_flash = 1'b0; end
                   else m_cnt++;
                2: if (m_cnt == FLASH_T - 1) begin m_cnt = 0; m_state = 3; end
                   else begin m_cnt++; m_flash = ~m_flash; end
                3: if (m_cnt == YELLOW_T - 1) begin m_cnt = 0; m_state = 4; end
                   else m_cnt++;
                4: if (m_cnt == LEFT_T - 1) begin m_cnt = 0; m_state = 0; end
                   else m_cnt++;
                5: if (!n) begin m_state = 0; m_axis = 1'b1; m_flash = 1'b0; end
                   else m_flash = ~m_flash;
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic logic [29:0] m_out();
        logic [3:0] m, vr, vy, vl, vg, pr, pg;
        logic [2:0] ph;
        m = amask(m_axis);
        vr = 4'hF; vy = 4'h0; vl = 4'h0; vg = 4'h0; pr = 4'hF; pg = 4'h0;
        case (m_state)
            1: begin vg = m; vr = ~m; if (m_walk) begin pg = m; pr = ~m; end end
            2: begin vg = m; vr = ~m; if (m_walk) begin pr = ~m; pg = m_flash ? m : 4'h0; end end
            3: begin vy = m; vr = ~m; end
            4: begin vl = m; vr = 4'hF; end
            5: begin vr = 4'h0; pr = 4'h0; vy = m_flash ? 4'hF : 4'h0; end
            default: ;
        endcase
        ph = 3'(m_state);
        return {vr, vy, vl, vg, pr, pg, m_ack, ph, m_axis};
    endfunction

    task automatic cyc(input logic t, input logic [1:0] pr, input logic n);
        tick = t; ped_req = pr; night = n;
        m_step(t, pr, n);
        sb_q.push_back(m_out());
        @(posedge Cp); #1;
        check_eq("sb", 32'(dut_vec), 32'(sb_q.pop_front()));
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; ped_req = 2'b00; night = 1'b0;
        m_reset();
        @(posedge Cp); #1;
        check_eq("rst_vec", 32'(dut_vec), 32'(RST_VEC));
        reset = 1'b1;

        // Free-running sequence, axis 0 first.
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("g0_vehg", veh_g, 4'b0011);
        check_eq("g0_vehr", veh_r, 4'b1100);
        check_eq("g0_pedr", ped_r, 4'hF);
        repeat (29) cyc(1'b1, 2'b00, 1'b0);
        check_eq("yel_phase", phase, 3'd3);
        repeat (3) cyc(1'b1, 2'b00, 1'b0);
        check_eq("left_phase", phase, 3'd4);
        check_eq("left_vehl", veh_l, 4'b0011);
        check_eq("left_vehr", veh_r, 4'hF);
        repeat (8) cyc(1'b1, 2'b00, 1'b0);
        check_eq("ar_phase", phase, 3'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("g1_phase", phase, 3'd1);
        check_eq("g1_vehg", veh_g, 4'b1100);

        // Pedestrian request on axis 0 during the axis 1 green.
        repeat (5) cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b01, 1'b0);
        repeat (35) cyc(1'b1, 2'b00, 1'b0);
        check_eq("walk0_ack", ped_ack, 2'b01);
        check_eq("walk0_pedg", ped_g, 4'b0011);
        repeat (21) cyc(1'b1, 2'b00, 1'b0);
        check_eq("walk0_end_pedg", ped_g, 4'b0011);
        check_eq("walk0_end_ack", ped_ack, 2'b00);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("flash_phase", phase, 3'd2);
        check_eq("flash_pedg0", ped_g, 4'b0000);
        check_eq("flash_pedr", ped_r, 4'b1100);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("flash_pedg1", ped_g, 4'b0011);
        repeat (5) cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("flash_exit", phase, 3'd3);
        repeat (12) cyc(1'b1, 2'b00, 1'b0);
        check_eq("g1_nowalk_ph", phase, 3'd1);
        check_eq("g1_nowalk_pedg", ped_g, 4'b0000);

        // Request exactly on the axis 1 green entry cycle.
        repeat (81) cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b10, 1'b0);
        check_eq("entry_ack", ped_ack, 2'b10);
        check_eq("entry_pedg", ped_g, 4'b1100);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("entry_ack_once", ped_ack, 2'b00);
        repeat (81) cyc(1'b1, 2'b00, 1'b0);
        check_eq("pend1_clr_ph", phase, 3'd1);
        check_eq("pend1_clr_pedg", ped_g, 4'b0000);

        // Night mode raised during green.
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 2'b00, 1'b1);
            if (phase == 3'd5) break;
        end
        check_eq("night_enter", phase, 3'd5);
        check_eq("night_y1", veh_y, 4'hF);
        check_eq("night_dark", 32'({veh_r, veh_g, ped_r, ped_g}), 32'd0);
        cyc(1'b1, 2'b00, 1'b1);
        check_eq("night_y0", veh_y, 4'h0);
        cyc(1'b1, 2'b00, 1'b1);
        check_eq("night_y2", veh_y, 4'hF);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("night_exit_ph", phase, 3'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("night_g_ph", phase, 3'd1);
        check_eq("night_g_axis", axis, 1'b0);

        // Tick stalled mid-yellow.
        for (int i = 0; i < 100; i++) begin
            if (m_state == 3 && m_cnt == 1) break;
            cyc(1'b1, 2'b00, 1'b0);
        end
        check_eq("reach_yellow", phase, 3'd3);
        repeat (100) cyc(1'b0, 2'b00, 1'b0);
        check_eq("stall_phase", phase, 3'd3);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("resume_yel", phase, 3'd3);
        cyc(1'b1, 2'b00, 1'b0);
        check_eq("resume_left", phase, 3'd4);

        // Asynchronous reset in the middle of LEFT.
        repeat (2) cyc(1'b1, 2'b00, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_rst", 32'(dut_vec), 32'(RST_VEC));
        m_reset();
        @(posedge Cp); #2;
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3) & $urandom_range(0, 3)),
                1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
